// File: rtl/mux_2_1_rr_arbiter_pkg.sv
// ============================================================================
// mux_2_1_rr_arbiter_pkg : shared defaults and grant FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_2_1_rr_arbiter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mux_2_1_rr_arbiter_mux.sv
// ============================================================================
// mux_2_1_w : combinational W-bit 2:1 multiplexer (y = sel ? d1 : d0)
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_2_1_w #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

`default_nettype wire

// File: rtl/mux_2_1_rr_arbiter.sv
// ============================================================================
// mux_2_1_rr_arbiter : two-requester round-robin burst arbiter onto one channel
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_2_1_rr_arbiter
  import mux_2_1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  input  logic [WIDTH-1:0] s0_data,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             sel,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  arb_state_e      state, state_nxt;
  logic            prio, prio_nxt;
  logic            sel_nxt;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            cap_reached;
  logic [WIDTH:0]  mux_y;

  assign cap_reached = (beat_cnt == CW'(MAX_BURST - 1));
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      prio     <= 1'b0;
      beat_cnt <= '0;
      sel      <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      beat_cnt <= beat_cnt_nxt;
      sel      <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    beat_cnt_nxt = beat_cnt;
    m_valid      = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s0_valid && s1_valid) state_nxt = prio ? ST_OWN1 : ST_OWN0;
        else if (s0_valid)        state_nxt = ST_OWN0;
        else if (s1_valid)        state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        m_valid  = s0_valid;
        s0_ready = m_ready;
        if (s0_valid && m_ready) begin
          if (s0_last || cap_reached) begin
            // Hand straight over when the other side waits, avoiding an idle bubble
            beat_cnt_nxt = '0;
            prio_nxt     = 1'b1;
            state_nxt    = s1_valid ? ST_OWN1 : ST_IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      ST_OWN1: begin
        m_valid  = s1_valid;
        s1_ready = m_ready;
        if (s1_valid && m_ready) begin
          if (s1_last || cap_reached) begin
            beat_cnt_nxt = '0;
            prio_nxt     = 1'b0;
            state_nxt    = s0_valid ? ST_OWN0 : ST_IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Select follows the owner; IDLE keeps the last owner on the mux
  always_comb begin
    sel_nxt = sel;
    case (state_nxt)
      ST_OWN0: sel_nxt = 1'b0;
      ST_OWN1: sel_nxt = 1'b1;
      default: sel_nxt = sel;
    endcase
  end

  mux_2_1_w #(
    .W (WIDTH + 1)
  ) u_mux (
    .sel (sel),
    .d0  ({s0_last, s0_data}),
    .d1  ({s1_last, s1_data}),
    .y   (mux_y)
  );

  assign m_last = mux_y[WIDTH];
  assign m_data = mux_y[WIDTH-1:0];

endmodule

`default_nettype wire
